// File: rtl/pkt_pkg.sv
// pkt_pkg: shared types for the packet read responder.
// Capture FSM states and the beat byte-count helper.
package pkt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HUNT,
    CAPTURE,
    DROP,
    LAST,
    DONE
  } rd_state_t;

  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/pkt_len_acc.sv
// pkt_len_acc: word counter, overflow flag and byte length.
// Length is latched on the final beat from counter + st_empty.
module pkt_len_acc
  import pkt_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int LEN_W = 16,
  localparam int BYTES = bytes_of(DATA_W),
  localparam int EMPTY_W = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               start,
  input  logic               step,
  input  logic               ovf,
  input  logic               fin,
  input  logic               trunc,
  input  logic [EMPTY_W-1:0] empty,
  output logic [ADDR_W-1:0]  cnt,
  output logic               at_max,
  output logic [LEN_W-1:0]   pkt_len,
  output logic               pkt_err
);

  localparam int MAX_WORDS = 2 ** ADDR_W;
  localparam logic [LEN_W-1:0] FULL_LEN =
    LEN_W'(MAX_WORDS * BYTES);

  logic [LEN_W-1:0] words;

  // a fresh sop beat is word 1; otherwise the beat lands at cnt+1
  assign words = start ? LEN_W'(1)
                       : LEN_W'(cnt) + LEN_W'(2);

  assign at_max = (cnt == ADDR_W'(MAX_WORDS - 1));

  // track last written index, truncation and final byte length
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      pkt_len <= '0;
      pkt_err <= 1'b0;
    end else if (clr) begin
      cnt     <= '0;
      pkt_len <= '0;
      pkt_err <= 1'b0;
    end else begin
      if (start)
        cnt <= '0;
      else if (step)
        cnt <= cnt + 1'b1;
      if (ovf)
        pkt_err <= 1'b1;
      if (fin)
        pkt_len <= trunc ? FULL_LEN
                 : words * LEN_W'(BYTES) - LEN_W'(empty);
    end
  end

endmodule

// File: rtl/pkt_rd_resp.sv
// pkt_rd_resp: captures one Avalon-ST packet into the buffer
// per rd_ctrl request, then reports length/error with rd_ctrl_rdy.
module pkt_rd_resp
  import pkt_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int LEN_W = 16,
  localparam int BYTES = bytes_of(DATA_W),
  localparam int EMPTY_W = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_ctrl,
  output logic               rd_ctrl_rdy,
  input  logic [DATA_W-1:0]  st_data,
  input  logic               st_valid,
  input  logic               st_sop,
  input  logic               st_eop,
  input  logic [EMPTY_W-1:0] st_empty,
  output logic               st_ready,
  output logic               buf_wr_en,
  output logic [ADDR_W-1:0]  buf_wr_addr,
  output logic [DATA_W-1:0]  buf_wr_data,
  output logic [LEN_W-1:0]   pkt_len,
  output logic               pkt_err
);

  rd_state_t state, nxt;

  logic              acc;
  logic              wr;
  logic [ADDR_W-1:0] waddr;
  logic              clr, start, step;
  logic              ovf, fin, trunc;
  logic              at_max;
  logic [ADDR_W-1:0] cnt;

  assign acc = st_valid & st_ready;

  pkt_len_acc #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_len (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .start   (start),
    .step    (step),
    .ovf     (ovf),
    .fin     (fin),
    .trunc   (trunc),
    .empty   (st_empty),
    .cnt     (cnt),
    .at_max  (at_max),
    .pkt_len (pkt_len),
    .pkt_err (pkt_err)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!reset)
      state <= IDLE;
    else
      state <= nxt;
  end

  // next state and per-beat write/length controls
  always_comb begin
    nxt   = state;
    wr    = 1'b0;
    waddr = '0;
    clr   = 1'b0;
    start = 1'b0;
    step  = 1'b0;
    ovf   = 1'b0;
    fin   = 1'b0;
    trunc = 1'b0;
    unique case (state)
      IDLE: begin
        if (rd_ctrl) begin
          nxt = HUNT;
          clr = 1'b1;
        end
      end
      HUNT: begin
        if (!rd_ctrl) begin
          nxt = IDLE;
        end else if (acc && st_sop) begin
          wr    = 1'b1;
          start = 1'b1;
          fin   = st_eop;
          nxt   = st_eop ? LAST : CAPTURE;
        end
      end
      CAPTURE: begin
        if (!rd_ctrl) begin
          nxt = IDLE;
        end else if (acc && st_sop) begin
          wr    = 1'b1;
          start = 1'b1;
          fin   = st_eop;
          nxt   = st_eop ? LAST : CAPTURE;
        end else if (acc && at_max) begin
          ovf   = 1'b1;
          fin   = st_eop;
          trunc = st_eop;
          nxt   = st_eop ? LAST : DROP;
        end else if (acc) begin
          wr    = 1'b1;
          waddr = cnt + 1'b1;
          step  = 1'b1;
          fin   = st_eop;
          nxt   = st_eop ? LAST : CAPTURE;
        end
      end
      DROP: begin
        if (!rd_ctrl) begin
          nxt = IDLE;
        end else if (acc && st_eop) begin
          fin   = 1'b1;
          trunc = 1'b1;
          nxt   = LAST;
        end
      end
      LAST: nxt = DONE;
      DONE: begin
        if (!rd_ctrl)
          nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // registered handshake outputs and buffer write stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      st_ready    <= 1'b0;
      rd_ctrl_rdy <= 1'b0;
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
    end else begin
      st_ready    <= (nxt == HUNT) || (nxt == CAPTURE)
                  || (nxt == DROP);
      rd_ctrl_rdy <= (nxt == DONE);
      buf_wr_en   <= wr;
      if (wr) begin
        buf_wr_addr <= waddr;
        buf_wr_data <= st_data;
      end
    end
  end

endmodule

// File: tb/tb_pkt_rd_resp.sv
// tb_pkt_rd_resp: randomized scoreboard bench for pkt_rd_resp.
// Packet-level model predicts buffer writes and length/error.
module tb_pkt_rd_resp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int LEN_W = 16;
  localparam int MAXW = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              rd_ctrl = 1'b0;
  logic              rd_ctrl_rdy;
  logic [DATA_W-1:0] st_data = '0;
  logic              st_valid = 1'b0;
  logic              st_sop = 1'b0;
  logic              st_eop = 1'b0;
  logic [1:0]        st_empty = '0;
  logic              st_ready;
  logic              buf_wr_en;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic [DATA_W-1:0] buf_wr_data;
  logic [LEN_W-1:0]  pkt_len;
  logic              pkt_err;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  typedef struct {
    logic [LEN_W-1:0] len;
    logic             err;
  } res_t;

  wr_t  wq[$];
  res_t rq[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_wr = 0;
  logic prev_rdy = 1'b0;

  pkt_rd_resp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_ctrl     (rd_ctrl),
    .rd_ctrl_rdy (rd_ctrl_rdy),
    .st_data     (st_data),
    .st_valid    (st_valid),
    .st_sop      (st_sop),
    .st_eop      (st_eop),
    .st_empty    (st_empty),
    .st_ready    (st_ready),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_addr (buf_wr_addr),
    .buf_wr_data (buf_wr_data),
    .pkt_len     (pkt_len),
    .pkt_err     (pkt_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: pops the scoreboard on every write and rdy rise
  always @(negedge clk) begin
    wr_t  w;
    res_t r;
    if (buf_wr_en === 1'b1) begin
      tests++;
      if (wq.size() == 0) begin
        fails++;
        $display("FAIL wr_unexpected: addr=%0d data=%h, required no write",
                 buf_wr_addr, buf_wr_data);
      end else begin
        w = wq.pop_front();
        if (buf_wr_addr !== w.a || buf_wr_data !== w.d) begin
          fails++;
          $display("FAIL wr_beat: addr=%0d data=%h, required addr=%0d data=%h",
                   buf_wr_addr, buf_wr_data, w.a, w.d);
        end
      end
      last_wr = cyc;
    end
    if (rd_ctrl_rdy === 1'b1 && !prev_rdy) begin
      tests++;
      if (rq.size() == 0) begin
        fails++;
        $display("FAIL rdy_unexpected: len=%0d err=%0b, required no rdy",
                 pkt_len, pkt_err);
      end else begin
        r = rq.pop_front();
        if (pkt_len !== r.len || pkt_err !== r.err) begin
          fails++;
          $display("FAIL pkt_result: len=%0d err=%0b, required len=%0d err=%0b",
                   pkt_len, pkt_err, r.len, r.err);
        end
        if (!r.err) begin
          tests++;
          if (cyc - last_wr != 1) begin
            fails++;
            $display("FAIL rdy_latency: %0d cycles after last write, required 1",
                     cyc - last_wr);
          end
        end
      end
    end
    prev_rdy <= (rd_ctrl_rdy === 1'b1);
  end

  task automatic chk(input string name, input logic ok,
                     input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // present one beat (entered and left at a negedge) until accepted
  task automatic beat(input logic [DATA_W-1:0] d, input logic s,
                      input logic e, input logic [1:0] em, input int gap);
    int g;
    st_valid = 1'b0;
    repeat (gap) @(negedge clk);
    st_valid = 1'b1;
    st_data  = d;
    st_sop   = s;
    st_eop   = e;
    st_empty = em;
    g = 0;
    while (st_ready !== 1'b1 && g < 40) begin
      @(negedge clk);
      g++;
    end
    chk("beat_accept", st_ready === 1'b1, 32'(st_ready), 32'd1);
    @(negedge clk);
    st_valid = 1'b0;
    st_sop   = 1'b0;
    st_eop   = 1'b0;
  endtask

  // wait for rdy, drop the request a cycle later, confirm idle
  task automatic finish_req();
    int g;
    g = 0;
    while (rd_ctrl_rdy !== 1'b1 && g < 60) begin
      @(negedge clk);
      g++;
    end
    chk("rdy_wait", rd_ctrl_rdy === 1'b1, 32'(rd_ctrl_rdy), 32'd1);
    @(negedge clk);
    chk("rdy_hold", rd_ctrl_rdy === 1'b1, 32'(rd_ctrl_rdy), 32'd1);
    rd_ctrl = 1'b0;
    @(negedge clk);
    chk("idle_rdy", rd_ctrl_rdy === 1'b0, 32'(rd_ctrl_rdy), 32'd0);
    chk("idle_ready", st_ready === 1'b0, 32'(st_ready), 32'd0);
  endtask

  // one request: junk non-sop beats, then an n-beat packet
  task automatic run_pkt(input int n, input int em, input int junk,
                         input int gmin, input int gmax);
    logic [DATA_W-1:0] d;
    res_t r;
    rd_ctrl = 1'b1;
    for (int j = 0; j < junk; j++)
      beat($urandom, 1'b0, 1'($urandom_range(0, 1)), 2'd0, 0);
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      if (i < MAXW)
        wq.push_back('{a: ADDR_W'(i), d: d});
      beat(d, i == 0, i == n - 1, (i == n - 1) ? 2'(em) : 2'd0,
           $urandom_range(gmin, gmax));
    end
    r.err = (n > MAXW);
    r.len = r.err ? LEN_W'(MAXW * 4) : LEN_W'(n * 4 - em);
    rq.push_back(r);
    finish_req();
  endtask

  initial begin
    logic [DATA_W-1:0] d;

    // held in reset with a random stream: everything stays zero
    for (int i = 0; i < 2; i++) begin
      st_valid = 1'($urandom_range(0, 1));
      st_sop   = 1'($urandom_range(0, 1));
      st_eop   = 1'($urandom_range(0, 1));
      st_data  = $urandom;
      rd_ctrl  = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_outputs",
          {rd_ctrl_rdy, st_ready, buf_wr_en, pkt_err} === 4'b0
          && buf_wr_addr === '0 && buf_wr_data === '0
          && pkt_len === '0,
          {rd_ctrl_rdy, st_ready, buf_wr_en, pkt_err}, 32'd0);
    end
    st_valid = 1'b0;
    st_sop   = 1'b0;
    st_eop   = 1'b0;
    rd_ctrl  = 1'b0;
    reset    = 1'b1;
    @(negedge clk);

    // directed cases
    run_pkt(1, 1, 0, 0, 0);
    run_pkt(5, 0, 0, 1, 3);
    run_pkt(3, 2, 2, 0, 1);
    run_pkt(20, 3, 0, 0, 1);
    run_pkt(17, 1, 0, 0, 0);
    run_pkt(16, 3, 1, 0, 0);

    // abort after two beats of a six-beat packet
    rd_ctrl = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      wq.push_back('{a: ADDR_W'(i), d: d});
      beat(d, i == 0, 1'b0, 2'd0, 0);
    end
    rd_ctrl = 1'b0;
    @(negedge clk);
    chk("abort_ready", st_ready === 1'b0, 32'(st_ready), 32'd0);
    chk("abort_rdy", rd_ctrl_rdy === 1'b0, 32'(rd_ctrl_rdy), 32'd0);
    rd_ctrl = 1'b1;
    for (int i = 0; i < 4; i++)
      beat($urandom, 1'b0, i == 3, 2'd0, 0);
    run_pkt(4, 1, 0, 0, 2);

    // randomized packets
    for (int k = 0; k < 12; k++)
      run_pkt($urandom_range(1, 20), $urandom_range(0, 3),
              $urandom_range(0, 2), 0, 2);

    // reset mid-packet: no write pulse, back to reset values
    rd_ctrl = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      wq.push_back('{a: ADDR_W'(i), d: d});
      beat(d, i == 0, 1'b0, 2'd0, 0);
    end
    @(negedge clk);
    reset    = 1'b0;
    st_valid = 1'b1;
    st_data  = $urandom;
    @(negedge clk);
    chk("midrst_wr", buf_wr_en === 1'b0, 32'(buf_wr_en), 32'd0);
    chk("midrst_ready", st_ready === 1'b0, 32'(st_ready), 32'd0);
    chk("midrst_len", pkt_len === '0, 32'(pkt_len), 32'd0);
    reset    = 1'b1;
    rd_ctrl  = 1'b0;
    st_valid = 1'b0;
    repeat (2) @(negedge clk);

    chk("sb_wr_drained", wq.size() == 0, 32'(wq.size()), 32'd0);
    chk("sb_res_drained", rq.size() == 0, 32'(rq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
